// File: rtl/csz_pkg.sv
// Shared parameters and types for the Scytale decryptor.
package csz_pkg;

  localparam int unsigned D_WIDTH       = 8;
  localparam int unsigned KEY_WIDTH     = 8;
  localparam int unsigned MAX_NOF_CHARS = 50;
  localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

  typedef enum logic [1:0] {
    IDLE,
    DECRYPT,
    DONE
  } state_e;

endpackage

// File: rtl/scytale_decryption_if.sv
// Stream/key/status bundle of the Scytale decryptor.
interface scytale_decryption_if;
  import csz_pkg::*;

  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;

  // Producer side: drives ciphertext and keys.
  modport master (
    output data_i, valid_i, key_N, key_M,
    input  busy, data_o, valid_o
  );

  // Decryptor side.
  modport slave (
    input  data_i, valid_i, key_N, key_M,
    output busy, data_o, valid_o
  );

endinterface

// File: rtl/scytale_decryption_division.sv
// Combinational unsigned divider: Q = N / D, R = N % D.
module division
  import csz_pkg::*;
(
  input  logic [D_WIDTH-1:0] N,
  input  logic [D_WIDTH-1:0] D,
  output logic [D_WIDTH-1:0] Q,
  output logic [D_WIDTH-1:0] R
);

  // Divide-by-zero yields all-ones quotient and passes N through as remainder.
  always_comb begin
    Q = '1;
    R = N;
    if (D != '0) begin
      Q = N / D;
      R = N % D;
    end
  end

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryptor: buffers ciphertext until the start token, then emits one
// plaintext character per clock, reading buf[(j % M) * N + j / M].
module scytale_decryption
  import csz_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  scytale_decryption_if.slave  bus
);

  localparam int unsigned IdxW  = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned ProdW = D_WIDTH + KEY_WIDTH;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      count_q, count_d;
  logic [IdxW-1:0]      j_q, j_d;
  logic [KEY_WIDTH-1:0] key_n_q, key_m_q;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 mem_we;
  logic                 key_load;

  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

  logic [D_WIDTH-1:0]   div_n;
  logic [D_WIDTH-1:0]   quo, rem;
  logic [IdxW-1:0]      src;

  assign div_n = D_WIDTH'(j_q);

  division u_division (
    .N (div_n),
    .D (key_m_q),
    .Q (quo),
    .R (rem)
  );

  // Full-width product, then truncated to the buffer index width.
  assign src = IdxW'(ProdW'(rem) * ProdW'(key_n_q) + ProdW'(quo));

  // Next-state, counters and output values.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    j_d      = j_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    mem_we   = 1'b0;
    key_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (bus.data_i == START_DECRYPTION_TOKEN) begin
            key_load = 1'b1;
            busy_d   = 1'b1;
            j_d      = '0;
            // Nothing to emit: spend a single busy cycle in DONE.
            if (count_q == '0 || bus.key_M == '0) begin
              state_d = DONE;
            end else begin
              state_d = DECRYPT;
            end
          end else if (count_q < IdxW'(MAX_NOF_CHARS)) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end
      DECRYPT: begin
        valid_d = 1'b1;
        data_d  = (src < count_q) ? mem_q[src] : '0;
        j_d     = j_q + 1'b1;
        if (j_q == count_q - 1'b1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        count_d = '0;
        j_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counters, sampled keys and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      j_q     <= '0;
      key_n_q <= '0;
      key_m_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      if (key_load) begin
        key_n_q <= bus.key_N;
        key_m_q <= bus.key_M;
      end
    end
  end

  // Character buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q] <= bus.data_i;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;

endmodule

// File: tb/tb_scytale_decryption.sv
// Scoreboard bench for the Scytale decryptor.
module tb_scytale_decryption;
  import csz_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n;

  scytale_decryption_if bus ();

  scytale_decryption dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          cyc = 0;
  int          token_cyc = 0;
  int          first_cyc = -1;
  int          out_cnt = 0;
  logic [7:0]  last_exp = '0;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: plaintext[j] = buf[(j % M) * N + j / M], index truncated to 6 bits.
  function automatic logic [7:0] model(input byte_q_t msg, input int cnt, input int j,
                                       input int n, input int m);
    int s;
    s = ((j % m) * n + j / m) & 63;
    return (s < cnt) ? msg[s] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every valid_o pops one expected character.
  always @(negedge clk) begin
    if (rst_n && bus.valid_o) begin
      if (out_cnt == 0) first_cyc = cyc;
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_out", 32'(exp_q.size()), 32'd1);
      end else begin
        last_exp = exp_q.pop_front();
        check("data_o", 32'(bus.data_o), 32'(last_exp));
      end
    end
  end

  // Feed a message then the token; push expected plaintext at the token.
  task automatic send_msg(input byte_q_t msg, input logic [7:0] kn, input logic [7:0] km);
    int cnt;
    cnt = (msg.size() > 50) ? 50 : msg.size();
    out_cnt   = 0;
    first_cyc = -1;
    bus.key_N = kn;
    bus.key_M = km;
    foreach (msg[i]) begin
      @(posedge clk); #1;
      bus.valid_i = 1'b1;
      bus.data_i  = msg[i];
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b1;
    bus.data_i  = START_DECRYPTION_TOKEN;
    if (cnt != 0 && km != 0) begin
      for (int j = 0; j < cnt; j++) exp_q.push_back(model(msg, cnt, j, kn, km));
    end
    @(posedge clk); #1;
    token_cyc   = cyc;
    bus.valid_i = 1'b0;
    // Keys changing after the token must not matter.
    bus.key_N = kn + 8'd3;
    bus.key_M = km + 8'd1;
  endtask

  // Wait for busy to fall; optionally hammer valid_i while busy.
  task automatic wait_done(input bit garbage, input int exp_busy, input int exp_outs);
    int  busy_cnt = 0;
    bit  done = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      bus.valid_i = garbage && bus.busy;
      bus.data_i  = 8'h5A;
      if (busy_cnt > 0 && !bus.busy) begin
        done = 1;
        break;
      end
    end
    bus.valid_i = 1'b0;
    check("done_in_time", 32'(done), 32'd1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("out_count", out_cnt, exp_outs);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (exp_outs > 0) begin
      check("first_latency", first_cyc - token_cyc, 32'd1);
      check("data_hold", 32'(bus.data_o), 32'(last_exp));
    end
  endtask

  initial begin
    byte_q_t m;
    bit      seen;
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.key_N   = '0;
    bus.key_M   = '0;

    // Reset values, held and after release.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid_o), 32'd0);
    check("rst_data", 32'(bus.data_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_valid", 32'(bus.valid_o), 32'd0);
    end

    // Nominal.
    send_msg(str2q("ADBECF"), 8'd2, 8'd3);
    wait_done(1'b0, 7, 6);

    // Back-to-back, valid_i driven while busy.
    send_msg(str2q("ADBECF"), 8'd2, 8'd3);
    wait_done(1'b1, 7, 6);
    send_msg(str2q("HLE LOL"), 8'd1, 8'd7);
    wait_done(1'b0, 8, 7);

    // Overflow: 55 chars, only first 50 kept.
    m.delete();
    for (int i = 0; i < 55; i++) m.push_back(8'h41 + 8'(i % 26));
    send_msg(m, 8'd5, 8'd10);
    wait_done(1'b0, 51, 50);

    // Degenerate: empty buffer, then key_M == 0.
    m.delete();
    send_msg(m, 8'd2, 8'd3);
    wait_done(1'b0, 1, 0);
    send_msg(str2q("ABC"), 8'd2, 8'd0);
    wait_done(1'b0, 1, 0);
    send_msg(str2q("ADBECF"), 8'd2, 8'd3);
    wait_done(1'b0, 7, 6);

    // Inconsistent keys: some indices fall outside the buffer and read as zero.
    send_msg(str2q("WXYZ"), 8'd3, 8'd2);
    wait_done(1'b0, 5, 4);

    // Asynchronous reset after two outputs.
    send_msg(str2q("ADBECF"), 8'd2, 8'd3);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (out_cnt >= 2) begin
        seen = 1;
        break;
      end
    end
    check("abort_reached", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.valid_o), 32'd0);
    exp_q.delete();
    out_cnt = 0;
    repeat (4) @(negedge clk);
    check("abort_no_valid", 32'(out_cnt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_msg(str2q("ADBECF"), 8'd2, 8'd3);
    wait_done(1'b0, 7, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
